// File: rtl/traffic_conflict_monitor_pkg.sv
// rtl/traffic_conflict_monitor_pkg.sv - shared lamp encodings, road indices and fault codes
// Imported by the monitor top and the per-road tracker.
package traffic_pkg;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  localparam logic [1:0] ROAD_M1 = 2'd0;
  localparam logic [1:0] ROAD_M2 = 2'd1;
  localparam logic [1:0] ROAD_MT = 2'd2;
  localparam logic [1:0] ROAD_S  = 2'd3;

  typedef enum logic [2:0] {
    FLT_NONE     = 3'd0,
    FLT_CONFLICT = 3'd1,
    FLT_INVALID  = 3'd2,
    FLT_SKIP_YEL = 3'd3,
    FLT_SHORT_YEL = 3'd4,
    FLT_STUCK    = 3'd5
  } fault_code_e;

  function automatic logic lamp_valid(input logic [2:0] lamp);
    return (lamp == LAMP_RED) || (lamp == LAMP_YEL) || (lamp == LAMP_GRN);
  endfunction

  function automatic logic [1:0] lowest_road(input logic [3:0] mask);
    if (mask[0]) return 2'd0;
    else if (mask[1]) return 2'd1;
    else if (mask[2]) return 2'd2;
    else if (mask[3]) return 2'd3;
    else return 2'd0;
  endfunction

endpackage

// File: rtl/traffic_conflict_monitor_if.sv
// rtl/traffic_conflict_monitor_if.sv - lamp bus between signal controller, monitor and lamp drivers
// master = controller/driver side, slave = monitor.
interface traffic_conflict_monitor_if;
  logic [2:0] light_M1_in;
  logic [2:0] light_M2_in;
  logic [2:0] light_MT_in;
  logic [2:0] light_S_in;
  logic       clr_fault;
  logic [2:0] light_M1;
  logic [2:0] light_M2;
  logic [2:0] light_MT;
  logic [2:0] light_S;
  logic       fault;
  logic [2:0] fault_code;
  logic [1:0] fault_road;

  modport master (
    output light_M1_in, light_M2_in, light_MT_in, light_S_in, clr_fault,
    input  light_M1, light_M2, light_MT, light_S, fault, fault_code, fault_road
  );

  modport slave (
    input  light_M1_in, light_M2_in, light_MT_in, light_S_in, clr_fault,
    output light_M1, light_M2, light_MT, light_S, fault, fault_code, fault_road
  );
endinterface

// File: rtl/traffic_conflict_monitor_tracker.sv
// rtl/traffic_conflict_monitor_tracker.sv - per-road lamp history and sequence checks
// Flags active/invalid lamps and illegal transitions against the previous sample.
module light_road_tracker
  import traffic_pkg::*;
#(
  parameter int MIN_YELLOW = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] lamp,
  output logic       active,
  output logic       invalid,
  output logic       skipped,
  output logic       short_yel
);
  localparam int YW = $clog2(MIN_YELLOW + 1);

  logic [2:0]    prev_q, prev_d;
  logic [YW-1:0] ycnt_q, ycnt_d;
  logic          first_q, first_d;
  logic          check_en;

  always_comb begin
    invalid  = !lamp_valid(lamp);
    active   = (lamp == LAMP_GRN) || (lamp == LAMP_YEL);
    // No history to judge against right after reset or after a garbage sample
    check_en = !first_q && lamp_valid(prev_q);
    skipped  = check_en && (((prev_q == LAMP_GRN) && (lamp == LAMP_RED)) ||
                            ((prev_q == LAMP_YEL) && (lamp == LAMP_GRN)));
    short_yel = check_en && (prev_q == LAMP_YEL) && (lamp == LAMP_RED) &&
                (ycnt_q < YW'(MIN_YELLOW));
    prev_d  = lamp;
    first_d = 1'b0;
    ycnt_d  = '0;
    if (lamp == LAMP_YEL) begin
      ycnt_d = (ycnt_q == YW'(MIN_YELLOW)) ? ycnt_q : ycnt_q + YW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q  <= LAMP_RED;
      ycnt_q  <= '0;
      first_q <= 1'b1;
    end else begin
      prev_q  <= prev_d;
      ycnt_q  <= ycnt_d;
      first_q <= first_d;
    end
  end
endmodule

// File: rtl/traffic_conflict_monitor.sv
// rtl/traffic_conflict_monitor.sv - lamp conflict/sequence monitor with latched fail-safe red flash
// Optional stuck-input watchdog is built when TRAFFIC_STUCK_WATCHDOG_EN is defined.
module traffic_conflict_monitor
  import traffic_pkg::*;
#(
  parameter int MIN_YELLOW = 3,
  parameter int FLASH_HALF = 4,
  parameter int MAX_STATIC = 16
) (
  input logic clk,
  input logic rst,
  traffic_conflict_monitor_if.slave bus
);
  localparam int FW = $clog2(FLASH_HALF + 1);

  logic [3:0][2:0] lamp_in;
  logic [3:0]      act, inv, skip, shrt, conf_mask;
  logic            stuck;
  fault_code_e     det_code;
  logic [1:0]      det_road;

  logic            fault_q, fault_d;
  fault_code_e     code_q, code_d;
  logic [1:0]      road_q, road_d;
  logic            flash_on_q, flash_on_d;
  logic [FW-1:0]   fcnt_q, fcnt_d;
  logic [3:0][2:0] out_q, out_d;

  assign lamp_in[ROAD_M1] = bus.light_M1_in;
  assign lamp_in[ROAD_M2] = bus.light_M2_in;
  assign lamp_in[ROAD_MT] = bus.light_MT_in;
  assign lamp_in[ROAD_S]  = bus.light_S_in;

  for (genvar i = 0; i < 4; i++) begin : g_road
    light_road_tracker #(.MIN_YELLOW(MIN_YELLOW)) u_tracker (
      .clk       (clk),
      .rst       (rst),
      .lamp      (lamp_in[i]),
      .active    (act[i]),
      .invalid   (inv[i]),
      .skipped   (skip[i]),
      .short_yel (shrt[i])
    );
  end

`ifdef TRAFFIC_STUCK_WATCHDOG_EN
  localparam int SW = $clog2(MAX_STATIC + 1);
  logic [SW-1:0]   static_q, static_d;
  logic [3:0][2:0] last_q, last_d;

  always_comb begin
    last_d   = lamp_in;
    static_d = '0;
    if (lamp_in == last_q) begin
      static_d = (static_q == SW'(MAX_STATIC)) ? static_q : static_q + SW'(1);
    end
    stuck = (static_q == SW'(MAX_STATIC));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      static_q <= '0;
      last_q   <= {4{LAMP_RED}};
    end else begin
      static_q <= static_d;
      last_q   <= last_d;
    end
  end
`else
  logic unused_max_static;
  assign unused_max_static = ^MAX_STATIC;
  assign stuck = 1'b0;
`endif

  always_comb begin
    // M1 may share the junction with M2 or MT; every other active pair is a conflict
    conf_mask = '0;
    if (act[ROAD_S] && act[ROAD_M1]) begin
      conf_mask[ROAD_S] = 1'b1; conf_mask[ROAD_M1] = 1'b1;
    end
    if (act[ROAD_S] && act[ROAD_M2]) begin
      conf_mask[ROAD_S] = 1'b1; conf_mask[ROAD_M2] = 1'b1;
    end
    if (act[ROAD_S] && act[ROAD_MT]) begin
      conf_mask[ROAD_S] = 1'b1; conf_mask[ROAD_MT] = 1'b1;
    end
    if (act[ROAD_M2] && act[ROAD_MT]) begin
      conf_mask[ROAD_M2] = 1'b1; conf_mask[ROAD_MT] = 1'b1;
    end
    det_code = FLT_NONE;
    det_road = ROAD_M1;
    if (|conf_mask) begin
      det_code = FLT_CONFLICT;  det_road = lowest_road(conf_mask);
    end else if (|inv) begin
      det_code = FLT_INVALID;   det_road = lowest_road(inv);
    end else if (|skip) begin
      det_code = FLT_SKIP_YEL;  det_road = lowest_road(skip);
    end else if (|shrt) begin
      det_code = FLT_SHORT_YEL; det_road = lowest_road(shrt);
    end else if (stuck) begin
      det_code = FLT_STUCK;     det_road = ROAD_M1;
    end
  end

  always_comb begin
    fault_d    = fault_q;
    code_d     = code_q;
    road_d     = road_q;
    flash_on_d = flash_on_q;
    fcnt_d     = fcnt_q;
    if (!fault_q) begin
      if (det_code != FLT_NONE) begin
        fault_d    = 1'b1;
        code_d     = det_code;
        road_d     = det_road;
        flash_on_d = 1'b1;
        fcnt_d     = '0;
      end
    end else if (bus.clr_fault && (det_code == FLT_NONE)) begin
      fault_d = 1'b0;
      code_d  = FLT_NONE;
      road_d  = ROAD_M1;
    end else if (fcnt_q == FW'(FLASH_HALF - 1)) begin
      fcnt_d     = '0;
      flash_on_d = !flash_on_q;
    end else begin
      fcnt_d = fcnt_q + FW'(1);
    end
    // Override is driven from next-state so red appears on the same edge fault rises
    for (int i = 0; i < 4; i++) begin
      out_d[i] = fault_d ? (flash_on_d ? LAMP_RED : LAMP_OFF) : lamp_in[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_q    <= 1'b0;
      code_q     <= FLT_NONE;
      road_q     <= ROAD_M1;
      flash_on_q <= 1'b1;
      fcnt_q     <= '0;
      out_q      <= {4{LAMP_RED}};
    end else begin
      fault_q    <= fault_d;
      code_q     <= code_d;
      road_q     <= road_d;
      flash_on_q <= flash_on_d;
      fcnt_q     <= fcnt_d;
      out_q      <= out_d;
    end
  end

  assign bus.light_M1   = out_q[ROAD_M1];
  assign bus.light_M2   = out_q[ROAD_M2];
  assign bus.light_MT   = out_q[ROAD_MT];
  assign bus.light_S    = out_q[ROAD_S];
  assign bus.fault      = fault_q;
  assign bus.fault_code = code_q;
  assign bus.fault_road = road_q;
endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// tb/tb_traffic_conflict_monitor.sv - table-driven bench for traffic_conflict_monitor
// Lamp vectors are packed {S, MT, M2, M1}.
module tb_traffic_conflict_monitor;
  import traffic_pkg::*;

  localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001, O = 3'b000;
  localparam logic [2:0] X = 3'b011, W = 3'b111;

  typedef struct {
    logic        rst_first;
    logic [11:0] lamps;
    logic        clr;
    logic [11:0] exp_lamps;
    logic        exp_fault;
    logic [2:0]  exp_code;
    logic [1:0]  exp_road;
  } vec_t;

  typedef struct {
    int          len;
    logic [11:0] lamps;
  } phase_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;
  vec_t vecs[$];
  phase_t phases[6];

  traffic_conflict_monitor_if bus();

  traffic_conflict_monitor dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] L(input logic [2:0] m1, m2, mt, s);
    return {s, mt, m2, m1};
  endfunction

  function automatic vec_t mk(input logic r, input logic [11:0] lamps, input logic c,
                              input logic [11:0] e, input logic ef, input logic [2:0] ec,
                              input logic [1:0] er);
    vec_t v;
    v.rst_first = r; v.lamps = lamps; v.clr = c;
    v.exp_lamps = e; v.exp_fault = ef; v.exp_code = ec; v.exp_road = er;
    return v;
  endfunction

  function automatic logic [11:0] got_lamps();
    return {bus.light_S, bus.light_MT, bus.light_M2, bus.light_M1};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [11:0] lamps, input logic c);
    bus.light_M1_in = lamps[2:0];
    bus.light_M2_in = lamps[5:3];
    bus.light_MT_in = lamps[8:6];
    bus.light_S_in  = lamps[11:9];
    bus.clr_fault   = c;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(L(R, R, R, R), 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [11:0] rrrr, conf;
    int n;
    rrrr = L(R, R, R, R);
    drive(rrrr, 1'b0);

    // Asynchronous reset before any clock edge
    #2 rst = 1'b1;
    #1;
    check("reset_lamps", got_lamps(), rrrr);
    check("reset_fault", bus.fault, 1'b0);
    check("reset_code", bus.fault_code, 3'd0);
    check("reset_road", bus.fault_road, 2'd0);

    // A: M2/MT conflict, flash 4 on / 4 off, clear refused then accepted
    conf = L(G, G, G, R);
    vecs.push_back(mk(1, rrrr, 0, rrrr, 0, 0, 0));
    vecs.push_back(mk(0, L(G, R, R, R), 0, L(G, R, R, R), 0, 0, 0));
    for (int k = 0; k < 4; k++) vecs.push_back(mk(0, conf, 0, rrrr, 1, 1, 1));
    for (int k = 0; k < 4; k++) vecs.push_back(mk(0, conf, 0, 12'h000, 1, 1, 1));
    vecs.push_back(mk(0, conf, 0, rrrr, 1, 1, 1));
    vecs.push_back(mk(0, conf, 1, rrrr, 1, 1, 1));
    vecs.push_back(mk(0, L(G, Y, Y, R), 0, rrrr, 1, 1, 1));
    vecs.push_back(mk(0, L(G, Y, Y, R), 0, rrrr, 1, 1, 1));
    vecs.push_back(mk(0, L(G, Y, Y, R), 0, 12'h000, 1, 1, 1));
    vecs.push_back(mk(0, L(G, R, R, R), 1, L(G, R, R, R), 0, 0, 0));
    vecs.push_back(mk(0, L(G, R, R, R), 0, L(G, R, R, R), 0, 0, 0));
    // C: M1 yellow for only 2 cycles
    vecs.push_back(mk(1, rrrr, 0, rrrr, 0, 0, 0));
    vecs.push_back(mk(0, L(G, R, R, R), 0, L(G, R, R, R), 0, 0, 0));
    vecs.push_back(mk(0, L(Y, R, R, R), 0, L(Y, R, R, R), 0, 0, 0));
    vecs.push_back(mk(0, L(Y, R, R, R), 0, L(Y, R, R, R), 0, 0, 0));
    vecs.push_back(mk(0, rrrr, 0, rrrr, 1, 4, 0));
    // D: M1 green straight to red
    vecs.push_back(mk(1, rrrr, 0, rrrr, 0, 0, 0));
    vecs.push_back(mk(0, L(G, R, R, R), 0, L(G, R, R, R), 0, 0, 0));
    vecs.push_back(mk(0, rrrr, 0, rrrr, 1, 3, 0));
    // E: long (saturating) yellow is legal, then S yellow back to green
    vecs.push_back(mk(1, rrrr, 0, rrrr, 0, 0, 0));
    vecs.push_back(mk(0, L(R, R, R, G), 0, L(R, R, R, G), 0, 0, 0));
    for (int k = 0; k < 5; k++) vecs.push_back(mk(0, L(R, R, R, Y), 0, L(R, R, R, Y), 0, 0, 0));
    vecs.push_back(mk(0, rrrr, 0, rrrr, 0, 0, 0));
    vecs.push_back(mk(0, L(R, R, R, G), 0, L(R, R, R, G), 0, 0, 0));
    vecs.push_back(mk(0, L(R, R, R, Y), 0, L(R, R, R, Y), 0, 0, 0));
    vecs.push_back(mk(0, L(R, R, R, G), 0, rrrr, 1, 3, 3));
    // F: conflict outranks invalid; S/MT conflict flags MT as lowest
    vecs.push_back(mk(1, rrrr, 0, rrrr, 0, 0, 0));
    vecs.push_back(mk(0, L(X, R, G, G), 0, rrrr, 1, 1, 2));
    // G: invalid on M2 and S reports M2
    vecs.push_back(mk(1, rrrr, 0, rrrr, 0, 0, 0));
    vecs.push_back(mk(0, L(R, O, R, W), 0, rrrr, 1, 2, 1));
    // B: invalid S, later conflict keeps the original code
    vecs.push_back(mk(1, rrrr, 0, rrrr, 0, 0, 0));
    vecs.push_back(mk(0, L(R, R, R, X), 0, rrrr, 1, 2, 3));
    vecs.push_back(mk(0, L(R, G, R, G), 0, rrrr, 1, 2, 3));

    foreach (vecs[i]) begin
      if (vecs[i].rst_first) do_reset();
      drive(vecs[i].lamps, vecs[i].clr);
      step();
      check($sformatf("vec%0d_lamps", i), got_lamps(), vecs[i].exp_lamps);
      check($sformatf("vec%0d_fault", i), bus.fault, vecs[i].exp_fault);
      check($sformatf("vec%0d_code", i), bus.fault_code, vecs[i].exp_code);
      check($sformatf("vec%0d_road", i), bus.fault_road, vecs[i].exp_road);
    end

    // Reset in the dark half of the flash returns to red immediately
    n = 0;
    while (got_lamps() !== 12'h000 && n < 10) begin
      step();
      n++;
    end
    check("flash_off_reached", got_lamps(), 12'h000);
    #3 rst = 1'b1;
    #1;
    check("midfault_rst_lamps", got_lamps(), rrrr);
    check("midfault_rst_fault", bus.fault, 1'b0);
    check("midfault_rst_code", bus.fault_code, 3'd0);

    // Legal controller program, three full rounds
    phases[0] = '{8, L(G, G, R, R)};
    phases[1] = '{3, L(G, Y, R, R)};
    phases[2] = '{6, L(G, R, G, R)};
    phases[3] = '{3, L(Y, R, Y, R)};
    phases[4] = '{4, L(R, R, R, G)};
    phases[5] = '{3, L(R, R, R, Y)};
    do_reset();
    for (int c = 0; c < 3; c++) begin
      for (int p = 0; p < 6; p++) begin
        for (int k = 0; k < phases[p].len; k++) begin
          drive(phases[p].lamps, 1'b0);
          step();
          check($sformatf("legal_c%0d_p%0d_out", c, p), got_lamps(), phases[p].lamps);
          check($sformatf("legal_c%0d_p%0d_fault", c, p), bus.fault, 1'b0);
        end
      end
    end

`ifdef TRAFFIC_STUCK_WATCHDOG_EN
    do_reset();
    n = 0;
    while (bus.fault !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    check("stuck_fault", bus.fault, 1'b1);
    check("stuck_code", bus.fault_code, 3'd5);
    check("stuck_road", bus.fault_road, 2'd0);
    #3 rst = 1'b1;
    #1;
    check("stuck_rst_lamps", got_lamps(), rrrr);
    check("stuck_rst_fault", bus.fault, 1'b0);
`endif

    rst = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
